mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  MEM-stage load/store controller directly downstream of the EX stage (via the EX/MEM register).
//  Consumes aluop, mem_addr and reg2 (store data), runs one data-bus transaction per memory
//  instruction over a req/ack handshake, and stalls the pipeline until the transaction is done.
//  Holds the LLbit register for LL/SC. Non-memory instructions pass through with zero latency.
// PARAMETERS
//  TIMEOUT   64  cycles to wait for bus_ack_i before aborting with bus_err_o
//  CNT_W     7   width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT
// PORTS
//  clk          in   1   rising-edge clock
//  rst          in   1   asynchronous reset, active-low
//  aluop_i      in   8   EX/MEM aluop (`EXE_LB/LBU/LH/LHU/LW/SB/SH/SW/LL/SC_OP from defines.v)
//  mem_addr_i   in   32  effective address
//  reg2_i       in   32  store data
//  wd_i         in   5   destination register
//  wreg_i       in   1   destination write enable
//  wdata_i      in   32  EX result for non-memory ops
//  llbit_clr_i  in   1   clear LLbit (exception/ERET); wins over any set
//  bus_rdata_i  in   32  bus read data, valid with bus_ack_i
//  bus_ack_i    in   1   bus acknowledge, 1 cycle
//  wd_o         out  5   = wd_i
//  wreg_o       out  1   writeback enable
//  wdata_o      out  32  writeback data
//  bus_req_o    out  1   bus request
//  bus_we_o     out  1   1 = write
//  bus_addr_o   out  32  {mem_addr_i[31:2],2'b00}
//  bus_sel_o    out  4   byte lanes, big-endian: addr[1:0]=00 -> 4'b1000
//  bus_wdata_o  out  32  store data replicated to the selected lane(s)
//  stallreq_o   out  1   stall request to the pipeline controller
//  addr_err_o   out  1   misaligned access (comb.)
//  bus_err_o    out  1   1-cycle pulse on timeout
// BEHAVIOUR
//  - Reset (rst=0, asynchronous): FSM=IDLE, LLbit=0, counter=0; bus_req_o=0, bus_err_o=0.
//    Comb. outputs follow their inputs, so stallreq_o=0 for non-memory ops.
//  - FSM states:
//    - IDLE -> REQ when a memory op is present, aligned, and not an SC with LLbit=0.
//    - REQ: bus_req_o=1; addr, we, sel and wdata held stable.
//      - ack sampled -> DONE; the read data is captured into a register.
//      - counter reaches TIMEOUT -> DONE with the error flag set.
//    - DONE -> IDLE unconditionally after 1 cycle.
//  - stallreq_o=1 for a memory op in IDLE or REQ; 0 in DONE, so the pipeline advances exactly once.
//    Load-to-use latency is ack + 1 cycle.
//  - Loads extend from the captured data (LB/LH sign-extend, LBU/LHU zero-extend):
//    - byte lane = 3 - addr[1:0];
//    - LH/LHU: addr[1]=0 -> bits [31:16];
//    - LW/LL: full word.
//  - Alignment: LH/LHU/SH need addr[0]=0; LW/SW/LL/SC need addr[1:0]=0.
//    On violation: addr_err_o=1, wreg_o=0, no bus request, no stall.
//  - LL: LLbit<=1 on the cycle ack is sampled.
//  - SC with LLbit=1:
//    - store word; wdata_o=1 in DONE;
//    - LLbit<=0 at ack.
//  - SC with LLbit=0: no bus request, no stall, wdata_o=0, wreg_o=wreg_i.
//  - llbit_clr_i=1 in the same cycle as an LL ack -> LLbit=0.
//  - Timeout: bus_err_o pulses in the DONE cycle; wreg_o=0; LLbit unchanged.
//  - Non-memory ops: wdata_o=wdata_i, wreg_o=wreg_i, no stall.
//  - Stores drive wreg_o=0.
//  - Reset mid-REQ drops bus_req_o immediately; a late ack is ignored in IDLE.
//  - bus_ack_i outside REQ is ignored.
// TESTING
//  1. LB, addr 0x1003, ack after 3 cycles with rdata 0x112233F4:
//     stall for 4 cycles, then wdata_o=0xFFFFFFF4, bus_sel_o=4'b0001.
//  2. SH 0xBEEF, addr 0x2002:
//     bus_sel_o=4'b0011, bus_wdata_o=0xBEEFBEEF, bus_we_o=1, wreg_o=0.
//  3. LL 0x3000 (ack 1 cycle), then SC 0x3000:
//     the store is issued and wdata_o=1.
//     A second SC issues no bus request, wdata_o=0, and does not stall.
//  4. LL, then llbit_clr_i pulse, then SC -> SC fails, wdata_o=0.
//  5. LW at 0x4002 -> addr_err_o=1, wreg_o=0, bus_req_o never asserted.
//  6. LW with no ack -> stall for TIMEOUT+1 cycles, then a single bus_err_o pulse.
//     Assert rst=0 mid-REQ: bus_req_o=0 in the same cycle.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store controller: one req/ack bus transaction per memory op, a pipeline
// stall while it is outstanding, load extension, and the LLbit used by LL/SC.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic        llbit_clr_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  output logic        stallreq_o,
  output logic        addr_err_o,
  output logic        bus_err_o
);

  localparam logic [7:0] OpLb  = 8'b1110_0000;
  localparam logic [7:0] OpLbu = 8'b1110_0100;
  localparam logic [7:0] OpLh  = 8'b1110_0001;
  localparam logic [7:0] OpLhu = 8'b1110_0101;
  localparam logic [7:0] OpLw  = 8'b1110_0011;
  localparam logic [7:0] OpSb  = 8'b1110_1000;
  localparam logic [7:0] OpSh  = 8'b1110_1001;
  localparam logic [7:0] OpSw  = 8'b1110_1011;
  localparam logic [7:0] OpLl  = 8'b1111_0000;
  localparam logic [7:0] OpSc  = 8'b1111_1000;

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             llbit_q, llbit_d;
  logic             err_q, err_d;
  logic [31:0]      rdata_q, rdata_d;

  logic        is_load, is_store, is_ll, is_sc;
  logic        is_byte, is_half, is_word, sign_ext;
  logic        misaligned, go;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_ll    = 1'b0;
    is_sc    = 1'b0;
    is_byte  = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    sign_ext = 1'b0;
    case (aluop_i)
      OpLb:    begin is_load = 1'b1;  is_byte = 1'b1; sign_ext = 1'b1; end
      OpLbu:   begin is_load = 1'b1;  is_byte = 1'b1; end
      OpLh:    begin is_load = 1'b1;  is_half = 1'b1; sign_ext = 1'b1; end
      OpLhu:   begin is_load = 1'b1;  is_half = 1'b1; end
      OpLw:    begin is_load = 1'b1;  is_word = 1'b1; end
      OpLl:    begin is_load = 1'b1;  is_word = 1'b1; is_ll = 1'b1; end
      OpSb:    begin is_store = 1'b1; is_byte = 1'b1; end
      OpSh:    begin is_store = 1'b1; is_half = 1'b1; end
      OpSw:    begin is_store = 1'b1; is_word = 1'b1; end
      OpSc:    begin is_store = 1'b1; is_word = 1'b1; is_sc = 1'b1; end
      default: ;
    endcase
  end

  assign misaligned = (is_half & mem_addr_i[0]) | (is_word & (mem_addr_i[1:0] != 2'b00));
  // A failing SC (LLbit clear) completes in IDLE without touching the bus.
  assign go = (is_load | is_store) & ~misaligned & ~(is_sc & ~llbit_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    llbit_d = llbit_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        err_d = 1'b0;
        if (go) state_d = StReq;
      end
      StReq: begin
        if (bus_ack_i) begin
          state_d = StDone;
          rdata_d = bus_rdata_i;
          if (is_ll) llbit_d = 1'b1;
          if (is_sc) llbit_d = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = StDone;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (llbit_clr_i) llbit_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      llbit_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      llbit_q <= llbit_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Big-endian lanes: address offset 0 is the most significant byte.
  always_comb begin
    unique case (mem_addr_i[1:0])
      2'b00:   ld_byte = rdata_q[31:24];
      2'b01:   ld_byte = rdata_q[23:16];
      2'b10:   ld_byte = rdata_q[15:8];
      default: ld_byte = rdata_q[7:0];
    endcase
    ld_half = mem_addr_i[1] ? rdata_q[15:0] : rdata_q[31:16];
    if (is_byte)      ld_data = {{24{sign_ext & ld_byte[7]}}, ld_byte};
    else if (is_half) ld_data = {{16{sign_ext & ld_half[15]}}, ld_half};
    else              ld_data = rdata_q;
  end

  always_comb begin
    wd_o        = wd_i;
    wreg_o      = wreg_i;
    wdata_o     = wdata_i;
    bus_req_o   = (state_q == StReq);
    bus_we_o    = is_store;
    bus_addr_o  = {mem_addr_i[31:2], 2'b00};
    bus_sel_o   = 4'b0000;
    bus_wdata_o = '0;
    stallreq_o  = (state_q == StReq) | ((state_q == StIdle) & go);
    addr_err_o  = misaligned;
    bus_err_o   = (state_q == StDone) & err_q;

    if (is_byte) begin
      bus_sel_o   = 4'b1000 >> mem_addr_i[1:0];
      bus_wdata_o = {4{reg2_i[7:0]}};
    end else if (is_half) begin
      bus_sel_o   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
      bus_wdata_o = {2{reg2_i[15:0]}};
    end else if (is_word) begin
      bus_sel_o   = 4'b1111;
      bus_wdata_o = reg2_i;
    end

    if (misaligned) begin
      wreg_o = 1'b0;
    end else if (is_sc) begin
      wdata_o = {31'b0, (state_q == StDone) & ~err_q};
      if ((state_q == StDone) & err_q) wreg_o = 1'b0;
    end else if (is_store) begin
      wreg_o = 1'b0;
    end else if (is_load) begin
      wdata_o = ld_data;
      if ((state_q == StDone) & err_q) wreg_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus a randomized mix of memory
// ops compared against an arithmetic reference model of the load/store rules.
module tb_mem_access_ctrl;

  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;
  localparam logic [7:0] OP_LL  = 8'b1111_0000;
  localparam logic [7:0] OP_SC  = 8'b1111_1000;
  localparam logic [7:0] OP_NOP = 8'b0010_0101;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  aluop_i = OP_NOP;
  logic [31:0] mem_addr_i = '0, reg2_i = '0, wdata_i = '0, bus_rdata_i = '0;
  logic [4:0]  wd_i = '0;
  logic        wreg_i = 1'b0, llbit_clr_i = 1'b0, bus_ack_i = 1'b0;
  logic [4:0]  wd_o;
  logic        wreg_o, bus_req_o, bus_we_o, stallreq_o, addr_err_o, bus_err_o;
  logic [31:0] wdata_o, bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_sel_o;

  int checks = 0;
  int passes = 0;

  // Observations of the most recent do_op call.
  int          st, rq, er;
  logic [31:0] wd, bw, ba;
  logic        wr, ae, we;
  logic [3:0]  sl;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .llbit_clr_i(llbit_clr_i),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o), .stallreq_o(stallreq_o),
    .addr_err_o(addr_err_o), .bus_err_o(bus_err_o)
  );

  // ---------------- reference model ----------------
  function automatic int op_size(input logic [7:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB:        return 1;
      OP_LH, OP_LHU, OP_SH:        return 2;
      OP_LW, OP_SW, OP_LL, OP_SC:  return 4;
      default:                     return 0;
    endcase
  endfunction

  function automatic bit is_store_op(input logic [7:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW) || (op == OP_SC);
  endfunction

  function automatic logic [31:0] size_mask(input int s);
    return (s == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * s)) - 32'h1);
  endfunction

  function automatic logic [3:0] ref_sel(input logic [7:0] op, input logic [31:0] addr);
    int s, v;
    s = op_size(op);
    v = ((1 << s) - 1) << (4 - s - int'(addr[1:0]));
    return 4'(v);
  endfunction

  function automatic logic [31:0] ref_load(input logic [7:0] op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int s;
    logic [31:0] m, v;
    s = op_size(op);
    m = size_mask(s);
    v = (rdata >> (8 * (4 - s - int'(addr[1:0])))) & m;
    if ((op == OP_LB || op == OP_LH) && v[8 * s - 1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [7:0] op, input logic [31:0] d);
    int s;
    logic [31:0] v;
    s = op_size(op);
    v = '0;
    for (int k = 0; k < 4 / s; k++) v = v | ((d & size_mask(s)) << (8 * s * k));
    return v;
  endfunction

  // Runs one instruction through the stage, acking on the ack_at-th request cycle (0 = never),
  // and records what the DUT showed on the cycle the pipeline was released.
  task automatic do_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] d2,
                       input logic [31:0] ex_data, input int ack_at, input logic [31:0] rdata,
                       output int stalls, output int reqs, output int errs,
                       output logic [31:0] wdata_s, output logic wreg_s, output logic aerr_s,
                       output logic [3:0] sel_s, output logic [31:0] bw_s, output logic we_s,
                       output logic [31:0] baddr_s);
    @(negedge clk);
    aluop_i = op; mem_addr_i = addr; reg2_i = d2; wdata_i = ex_data; wreg_i = 1'b1;
    wd_i = 5'd9; bus_ack_i = 1'b0;
    stalls = 0; reqs = 0; errs = 0; wdata_s = '0; wreg_s = 1'b0; aerr_s = 1'b0;
    sel_s = '0; bw_s = '0; we_s = 1'b0; baddr_s = '0;
    for (int c = 0; c < 300; c++) begin
      #1;
      errs += int'(bus_err_o);
      if (bus_req_o) begin
        reqs++;
        sel_s = bus_sel_o; bw_s = bus_wdata_o; we_s = bus_we_o; baddr_s = bus_addr_o;
      end
      if (!stallreq_o) begin
        wdata_s = wdata_o; wreg_s = wreg_o; aerr_s = addr_err_o;
        break;
      end
      stalls++;
      if (bus_req_o && reqs == ack_at) begin
        bus_ack_i = 1'b1; bus_rdata_i = rdata;
      end else begin
        bus_rdata_i = $urandom;
      end
      @(negedge clk);
      bus_ack_i = 1'b0;
    end
    @(negedge clk);
    aluop_i = OP_NOP; wreg_i = 1'b0;
    #1 errs += int'(bus_err_o);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    aluop_i = OP_NOP; wdata_i = 32'hCAFE_0001; wreg_i = 1'b1; wd_i = 5'd17;
    #12;
    checks++; if (bus_req_o !== 1'b0) $display("FAIL rst_req got %b want 0", bus_req_o); else passes++;
    checks++; if (bus_err_o !== 1'b0) $display("FAIL rst_err got %b want 0", bus_err_o); else passes++;
    checks++; if (stallreq_o !== 1'b0) $display("FAIL rst_stall got %b want 0", stallreq_o); else passes++;
    checks++; if (wdata_o !== 32'hCAFE_0001) $display("FAIL rst_wdata got %h want cafe0001", wdata_o); else passes++;
    checks++; if (wd_o !== 5'd17) $display("FAIL rst_wd got %0d want 17", wd_o); else passes++;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_load_byte;
    do_op(OP_LB, 32'h1003, 32'h0, 32'h0, 3, 32'h1122_33F4, st, rq, er, wd, wr, ae, sl, bw, we, ba);
    checks++; if (st !== 4) $display("FAIL lb_stall got %0d want 4", st); else passes++;
    checks++; if (wd !== 32'hFFFF_FFF4) $display("FAIL lb_wdata got %h want fffffff4", wd); else passes++;
    checks++; if (sl !== 4'b0001) $display("FAIL lb_sel got %b want 0001", sl); else passes++;
    checks++; if (ba !== 32'h1000) $display("FAIL lb_addr got %h want 00001000", ba); else passes++;
    checks++; if (wr !== 1'b1) $display("FAIL lb_wreg got %b want 1", wr); else passes++;
  endtask

  task automatic test_store_half;
    do_op(OP_SH, 32'h2002, 32'h1234_BEEF, 32'h0, 1, 32'h0, st, rq, er, wd, wr, ae, sl, bw, we, ba);
    checks++; if (sl !== 4'b0011) $display("FAIL sh_sel got %b want 0011", sl); else passes++;
    checks++; if (bw !== 32'hBEEF_BEEF) $display("FAIL sh_bwdata got %h want beefbeef", bw); else passes++;
    checks++; if (we !== 1'b1) $display("FAIL sh_we got %b want 1", we); else passes++;
    checks++; if (wr !== 1'b0) $display("FAIL sh_wreg got %b want 0", wr); else passes++;
  endtask

  task automatic test_ll_sc;
    do_op(OP_LL, 32'h3000, 32'h0, 32'h0, 1, 32'h1234_5678, st, rq, er, wd, wr, ae, sl, bw, we, ba);
    checks++; if (st !== 2) $display("FAIL ll_stall got %0d want 2", st); else passes++;
    checks++; if (wd !== 32'h1234_5678) $display("FAIL ll_wdata got %h want 12345678", wd); else passes++;
    do_op(OP_SC, 32'h3000, 32'hA5A5_0F0F, 32'h0, 2, 32'h0, st, rq, er, wd, wr, ae, sl, bw, we, ba);
    checks++; if (rq !== 2 || we !== 1'b1) $display("FAIL sc_req got %0d/%b want 2/1", rq, we); else passes++;
    checks++; if (bw !== 32'hA5A5_0F0F) $display("FAIL sc_bwdata got %h want a5a50f0f", bw); else passes++;
    checks++; if (wd !== 32'h1 || wr !== 1'b1) $display("FAIL sc_ok got %h/%b want 1/1", wd, wr); else passes++;
    do_op(OP_SC, 32'h3000, 32'h5555_5555, 32'h0, 1, 32'h0, st, rq, er, wd, wr, ae, sl, bw, we, ba);
    checks++; if (st !== 0 || rq !== 0) $display("FAIL sc2_stall got %0d/%0d want 0/0", st, rq); else passes++;
    checks++; if (wd !== 32'h0 || wr !== 1'b1) $display("FAIL sc2_fail got %h/%b want 0/1", wd, wr); else passes++;
  endtask

  task automatic test_llbit_clr;
    do_op(OP_LL, 32'h3004, 32'h0, 32'h0, 1, 32'h0, st, rq, er, wd, wr, ae, sl, bw, we, ba);
    @(negedge clk); llbit_clr_i = 1'b1;
    @(negedge clk); llbit_clr_i = 1'b0;
    do_op(OP_SC, 32'h3004, 32'h0, 32'h0, 1, 32'h0, st, rq, er, wd, wr, ae, sl, bw, we, ba);
    checks++; if (st !== 0 || rq !== 0 || wd !== 32'h0) $display("FAIL clr_sc got %0d/%0d/%h want 0/0/0", st, rq, wd); else passes++;
    // Clear held across the LL ack must win over the set.
    llbit_clr_i = 1'b1;
    do_op(OP_LL, 32'h3008, 32'h0, 32'h0, 1, 32'h0, st, rq, er, wd, wr, ae, sl, bw, we, ba);
    llbit_clr_i = 1'b0;
    do_op(OP_SC, 32'h3008, 32'h0, 32'h0, 1, 32'h0, st, rq, er, wd, wr, ae, sl, bw, we, ba);
    checks++; if (rq !== 0 || wd !== 32'h0) $display("FAIL clr_at_ack got %0d/%h want 0/0", rq, wd); else passes++;
  endtask

  task automatic test_misaligned;
    do_op(OP_LW, 32'h4002, 32'h0, 32'h0, 1, 32'h0, st, rq, er, wd, wr, ae, sl, bw, we, ba);
    checks++; if (ae !== 1'b1 || wr !== 1'b0) $display("FAIL lw_mis got %b/%b want 1/0", ae, wr); else passes++;
    checks++; if (rq !== 0 || st !== 0) $display("FAIL lw_mis_req got %0d/%0d want 0/0", rq, st); else passes++;
    do_op(OP_SH, 32'h2001, 32'h0, 32'h0, 1, 32'h0, st, rq, er, wd, wr, ae, sl, bw, we, ba);
    checks++; if (ae !== 1'b1 || rq !== 0) $display("FAIL sh_mis got %b/%0d want 1/0", ae, rq); else passes++;
  endtask

  task automatic test_timeout;
    do_op(OP_LW, 32'h5000, 32'h0, 32'h0, 0, 32'h0, st, rq, er, wd, wr, ae, sl, bw, we, ba);
    checks++; if (st !== TIMEOUT + 1) $display("FAIL to_stall got %0d want %0d", st, TIMEOUT + 1); else passes++;
    checks++; if (er !== 1) $display("FAIL to_err_pulses got %0d want 1", er); else passes++;
    checks++; if (wr !== 1'b0) $display("FAIL to_wreg got %b want 0", wr); else passes++;
  endtask

  task automatic test_reset_mid_req;
    @(negedge clk);
    aluop_i = OP_LW; mem_addr_i = 32'h6000; wreg_i = 1'b1; bus_ack_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus_req_o !== 1'b1) $display("FAIL mid_req_pre got %b want 1", bus_req_o); else passes++;
    rst = 1'b0;
    #1;
    checks++; if (bus_req_o !== 1'b0) $display("FAIL mid_req_drop got %b want 0", bus_req_o); else passes++;
    @(negedge clk); aluop_i = OP_NOP; rst = 1'b1;
    @(negedge clk); bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk); bus_ack_i = 1'b0;
    #1;
    checks++; if (bus_req_o !== 1'b0 || stallreq_o !== 1'b0) $display("FAIL late_ack got %b/%b want 0/0", bus_req_o, stallreq_o); else passes++;
    do_op(OP_LB, 32'h7000, 32'h0, 32'h0, 2, 32'h8011_2233, st, rq, er, wd, wr, ae, sl, bw, we, ba);
    checks++; if (st !== 3 || wd !== 32'hFFFF_FF80) $display("FAIL post_rst_lb got %0d/%h want 3/ffffff80", st, wd); else passes++;
  endtask

  task automatic test_random;
    logic [7:0]  ops [11];
    logic [7:0]  op;
    logic [31:0] addr, d2, exd, rdata, e_wd;
    logic        llbit_m, e_wr;
    int          s, dly, e_st, e_rq;
    bit          issued;
    ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW, OP_LL, OP_SC, OP_NOP};
    llbit_m = 1'b0;
    for (int i = 0; i < 80; i++) begin
      op = ops[$urandom_range(0, 10)];
      s = op_size(op);
      addr = $urandom; d2 = $urandom; exd = $urandom; rdata = $urandom;
      dly = $urandom_range(1, 4);
      if (s != 0 && $urandom_range(0, 3) != 0) addr = addr - (addr % s);
      do_op(op, addr, d2, exd, dly, rdata, st, rq, er, wd, wr, ae, sl, bw, we, ba);
      issued = 1'b0; e_st = 0; e_rq = 0; e_wd = wd; e_wr = 1'b1;
      if (s == 0) begin
        e_wd = exd;
      end else if (addr % s != 0) begin
        e_wr = 1'b0;
      end else if (op == OP_SC && !llbit_m) begin
        e_wd = 32'h0;
      end else begin
        issued = 1'b1; e_st = 1 + dly; e_rq = dly;
        if (op == OP_SC) begin e_wd = 32'h1; llbit_m = 1'b0; end
        else if (is_store_op(op)) e_wr = 1'b0;
        else e_wd = ref_load(op, addr, rdata);
        if (op == OP_LL) llbit_m = 1'b1;
      end
      checks++; if (st !== e_st || rq !== e_rq) $display("FAIL rnd%0d_timing op %h got %0d/%0d want %0d/%0d", i, op, st, rq, e_st, e_rq); else passes++;
      checks++; if (wr !== e_wr || wd !== e_wd) $display("FAIL rnd%0d_wb op %h got %b/%h want %b/%h", i, op, wr, wd, e_wr, e_wd); else passes++;
      checks++; if (ae !== (s != 0 && addr % s != 0)) $display("FAIL rnd%0d_aerr op %h got %b", i, op, ae); else passes++;
      if (issued) begin
        checks++; if (sl !== ref_sel(op, addr) || ba !== {addr[31:2], 2'b00} || we !== is_store_op(op)) $display("FAIL rnd%0d_bus op %h got %b/%h/%b want %b/%h/%b", i, op, sl, ba, we, ref_sel(op, addr), {addr[31:2], 2'b00}, is_store_op(op)); else passes++;
        if (is_store_op(op)) begin
          checks++; if (bw !== ref_store(op, d2)) $display("FAIL rnd%0d_bwdata op %h got %h want %h", i, op, bw, ref_store(op, d2)); else passes++;
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_load_byte;
    test_store_half;
    test_ll_sc;
    test_llbit_clr;
    test_misaligned;
    test_timeout;
    test_reset_mid_req;
    test_random;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
